// File: rtl/core_intc.sv
// core_intc: NSRC-line interrupt controller with lowest-index priority, a
// claim/EOI handshake and a 4-word register file.
// Ports:
//   clk, rst             - clock and synchronous active-high reset
//   src                  - interrupt source lines, synchronous to clk
//   reg_we               - register write strobe
//   reg_addr, reg_wdata  - register select and write data
//   reg_rdata            - register read data, combinational from reg_addr
//   irq                  - interrupt request to core control
//   irq_ack              - one-cycle acknowledge from core control
//   irq_id               - id of the claimed source
// Register map:
//   0 PEND  (read; write-1-to-clear edge bits)
//   1 MASK  (read/write)
//   2 EDGE  (read/write)
//   3 CLAIM (read {valid, id}; any write is EOI)
// Build option: define INTC_EDGE_EN to add edge-mode sources, the EDGE
// register and PEND write-1-to-clear.  Without it every source is level mode.
module core_intc #(
  parameter int NSRC = 8,
  parameter int IDW  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src,
  input  logic            reg_we,
  input  logic [1:0]      reg_addr,
  input  logic [31:0]     reg_wdata,
  output logic [31:0]     reg_rdata,
  output logic            irq,
  input  logic            irq_ack,
  output logic [IDW-1:0]  irq_id
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    SERVICE
  } state_t;

  state_t state;
  state_t state_n;

  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] pend_n;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] edg;
  logic [NSRC-1:0] act;
  logic [IDW-1:0]  win;
  logic            any;
  logic            valid;

  logic wr_mask;
  logic wr_eoi;
  logic claim;
  logic abort;
  logic eoi;

  // Upper write-data bits beyond NSRC are don't-care.
  logic unused_wdata;
  assign unused_wdata = ^reg_wdata;

  assign wr_mask = reg_we && (reg_addr == 2'd1);
  assign wr_eoi  = reg_we && (reg_addr == 2'd3);

  assign act = pend & mask;
  assign any = |act;

  // Scan downwards so the lowest active index is the last assignment.
  always_comb begin
    win = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (act[i]) win = IDW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (any) state_n = REQ;
      REQ: begin
        if (irq_ack)  state_n = any ? SERVICE : IDLE;
        else if (!any) state_n = IDLE;
      end
      SERVICE: if (wr_eoi) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    irq   = (state == REQ);
    claim = (state == REQ) && irq_ack && any;
    abort = (state == REQ) && irq_ack && !any;
    eoi   = (state == SERVICE) && wr_eoi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid  <= 1'b0;
      irq_id <= '0;
    end else if (claim) begin
      valid  <= 1'b1;
      irq_id <= win;
    end else if (abort || eoi) begin
      valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          mask <= '0;
    else if (wr_mask) mask <= reg_wdata[NSRC-1:0];
  end

`ifdef INTC_EDGE_EN
  logic            wr_pend;
  logic            wr_edge;
  logic [NSRC-1:0] prev;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] clr;
  logic [NSRC-1:0] claim_bit;

  assign wr_pend = reg_we && (reg_addr == 2'd0);
  assign wr_edge = reg_we && (reg_addr == 2'd2);

  always_ff @(posedge clk) begin
    if (rst) prev <= '0;
    else     prev <= src;
  end

  always_ff @(posedge clk) begin
    if (rst)          edg <= '0;
    else if (wr_edge) edg <= reg_wdata[NSRC-1:0];
  end

  always_comb begin
    claim_bit = '0;
    if (claim) claim_bit[win] = 1'b1;
  end

  assign rise = src & ~prev;
  assign clr  = (wr_pend ? reg_wdata[NSRC-1:0] : '0) | claim_bit;

  // A rising edge outranks a same-cycle clear; level bits track src.
  assign pend_n = (edg & (rise | (pend & ~clr))) | (~edg & src);
`else
  assign edg    = '0;
  assign pend_n = src;
`endif

  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else     pend <= pend_n;
  end

  always_comb begin
    reg_rdata = '0;
    unique case (reg_addr)
      2'd0: reg_rdata[NSRC-1:0] = pend;
      2'd1: reg_rdata[NSRC-1:0] = mask;
      2'd2: reg_rdata[NSRC-1:0] = edg;
      2'd3: begin
        reg_rdata[31]      = valid;
        reg_rdata[IDW-1:0] = irq_id;
      end
      default: reg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_core_intc.sv
// tb_core_intc: directed scenarios plus random traffic for core_intc,
// compared cycle by cycle against a behavioural model.
module tb_core_intc;

  localparam int NSRC = 8;
  localparam int IDW  = 3;
`ifdef INTC_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic [NSRC-1:0] src;
  logic            reg_we;
  logic [1:0]      reg_addr;
  logic [31:0]     reg_wdata;
  logic [31:0]     reg_rdata;
  logic            irq;
  logic            irq_ack;
  logic [IDW-1:0]  irq_id;

  core_intc #(
    .NSRC(NSRC),
    .IDW (IDW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .src      (src),
    .reg_we   (reg_we),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata),
    .irq      (irq),
    .irq_ack  (irq_ack),
    .irq_id   (irq_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: mode 0 = quiet, 1 = requesting, 2 = in service.
  logic [NSRC-1:0] m_pend = '0, m_mask = '0, m_edge = '0, m_prev = '0;
  logic [NSRC-1:0] n_pend, n_mask, n_edge, n_prev;
  logic            m_valid = 1'b0, n_valid;
  logic [IDW-1:0]  m_id = '0, n_id;
  int              m_mode = 0, n_mode;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(logic [NSRC-1:0] v);
    for (int i = 0; i < NSRC; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] m_read(logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0: r[NSRC-1:0] = m_pend;
      2'd1: r[NSRC-1:0] = m_mask;
      2'd2: r[NSRC-1:0] = m_edge;
      default: begin
        r[31]      = m_valid;
        r[IDW-1:0] = m_id;
      end
    endcase
    return r;
  endfunction

  task automatic model_step();
    logic [NSRC-1:0] act, clr;
    int w;
    if (rst) begin
      n_pend = '0; n_mask = '0; n_edge = '0; n_prev = '0;
      n_valid = 1'b0; n_id = '0; n_mode = 0;
      return;
    end
    act = m_pend & m_mask;
    w = lowest(act);
    n_pend = m_pend; n_mask = m_mask; n_edge = m_edge;
    n_valid = m_valid; n_id = m_id; n_mode = m_mode;
    n_prev = src;
    clr = '0;
    if (reg_we && reg_addr == 2'd1) n_mask = reg_wdata[NSRC-1:0];
    if (EDGE_EN && reg_we && reg_addr == 2'd2) n_edge = reg_wdata[NSRC-1:0];
    if (EDGE_EN && reg_we && reg_addr == 2'd0) clr = reg_wdata[NSRC-1:0];
    if (m_mode == 0) begin
      if (act != 0) n_mode = 1;
    end else if (m_mode == 1) begin
      if (irq_ack && act != 0) begin
        n_mode = 2; n_valid = 1'b1; n_id = IDW'(w); clr[w] = 1'b1;
      end else if (irq_ack) begin
        n_mode = 0; n_valid = 1'b0;
      end else if (act == 0) begin
        n_mode = 0;
      end
    end else begin
      if (reg_we && reg_addr == 2'd3) begin
        n_mode = 0; n_valid = 1'b0;
      end
    end
    n_pend = (m_edge & ((src & ~m_prev) | (m_pend & ~clr))) | (~m_edge & src);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    m_pend = n_pend; m_mask = n_mask; m_edge = n_edge; m_prev = n_prev;
    m_valid = n_valid; m_id = n_id; m_mode = n_mode;
    chk("irq", 32'(irq), 32'(m_mode == 1));
    chk("irq_id", 32'(irq_id), 32'(m_id));
    chk("rdata", reg_rdata, m_read(reg_addr));
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_we = 1'b0;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; src = '0; reg_we = 1'b0; reg_addr = '0;
    reg_wdata = '0; irq_ack = 1'b0;

    // Level source: request, claim, EOI, re-request.
    do_rst();
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_id", 32'(irq_id), 32'd0);
    src = 8'h01;
    wr(2'd1, 32'h01);
    tick();
    chk("lvl_irq", 32'(irq), 32'd1);
    reg_addr = 2'd3;
    ack();
    chk("lvl_id", 32'(irq_id), 32'd0);
    chk("lvl_claim", reg_rdata, 32'h8000_0000);
    chk("lvl_irq_svc", 32'(irq), 32'd0);
    wr(2'd3, 32'h0);
    chk("eoi_irq_lo", 32'(irq), 32'd0);
    tick();
    chk("eoi_irq_hi", 32'(irq), 32'd1);

    // Priority.
    do_rst();
    src = 8'h28;
    wr(2'd1, 32'hFF);
    tick();
    ack();
    chk("pri_id3", 32'(irq_id), 32'd3);
    wr(2'd3, 32'h0);
    tick();
    ack();
    chk("pri_id3b", 32'(irq_id), 32'd3);
    src = 8'h20;
    wr(2'd3, 32'h0);
    tick();
    ack();
    chk("pri_id5", 32'(irq_id), 32'd5);

    // Withdraw by mask, with an ack landing after act went to zero.
    do_rst();
    src = 8'h02;
    wr(2'd1, 32'h02);
    tick();
    ack();
    wr(2'd3, 32'h0);
    tick();
    chk("wd_irq_hi", 32'(irq), 32'd1);
    wr(2'd1, 32'h0);
    reg_addr = 2'd3;
    ack();
    chk("wd_irq_lo", 32'(irq), 32'd0);
    chk("wd_claim", reg_rdata, 32'h1);
    tick();
    chk("wd_stay", 32'(irq), 32'd0);

    // Reset while in service.
    do_rst();
    src = 8'h01;
    wr(2'd1, 32'h01);
    tick();
    ack();
    irq_ack = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    irq_ack = 1'b0;
    chk("svc_rst_irq", 32'(irq), 32'd0);
    chk("svc_rst_id", 32'(irq_id), 32'd0);
    for (int a = 0; a < 4; a++) begin
      reg_addr = 2'(a);
      #1;
      chk("svc_rst_reg", reg_rdata, 32'h0);
    end

`ifdef INTC_EDGE_EN
    // Edge pulse is held, then cleared by the claim.
    do_rst();
    src = '0;
    wr(2'd2, 32'h04);
    wr(2'd1, 32'h04);
    src = 8'h04;
    reg_addr = 2'd0;
    tick();
    src = 8'h00;
    tick();
    chk("edge_pend", reg_rdata, 32'h04);
    tick();
    chk("edge_hold", reg_rdata, 32'h04);
    ack();
    chk("edge_clr", reg_rdata, 32'h00);
    chk("edge_id", 32'(irq_id), 32'd2);

    // Edge set collides with W1C: set wins.
    do_rst();
    wr(2'd2, 32'h10);
    src = 8'h10;
    wr(2'd0, 32'h10);
    chk("coll_set", reg_rdata, 32'h10);
    wr(2'd0, 32'h10);
    chk("w1c_clr", reg_rdata, 32'h00);
`endif

    // Random traffic.
    do_rst();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom % 300) == 0;
      if (($urandom % 6) == 0) src[$urandom_range(NSRC - 1, 0)] ^= 1'b1;
      reg_we    = ($urandom % 6) == 0;
      reg_addr  = 2'($urandom % 4);
      reg_wdata = $urandom;
      irq_ack   = ($urandom % 3) == 0;
      tick();
    end
    rst = 1'b0; reg_we = 1'b0; irq_ack = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
